// File: rtl/fifo_uart_tx_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter.
// Latency: n/a (constants only).
// Backpressure: n/a.
package fifo_uart_tx_pkg;

   // FSM state encoding, kept as plain constants so legacy code can compare against them
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_LOAD  = 3'd1;
   localparam logic [2:0] ST_START = 3'd2;
   localparam logic [2:0] ST_DATA  = 3'd3;
   localparam logic [2:0] ST_STOP  = 3'd4;

   localparam int DEF_CLKS_PER_BIT = 4;
   localparam int DATA_W           = 8;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read-port bundle between the 16x8 FIFO (master) and the UART transmitter (slave).
// Latency: fifo_dout is valid the cycle after fifo_re.
// Backpressure: the consumer pulls with fifo_re only when fifo_empty is low.
interface fifo_uart_tx_if
   import fifo_uart_tx_pkg::*;
#(
   parameter int WIDTH = DATA_W
);
   logic             fifo_empty;
   logic [WIDTH-1:0] fifo_dout;
   logic             fifo_re;

   modport master (output fifo_empty, output fifo_dout, input fifo_re);
   modport slave  (input fifo_empty, input fifo_dout, output fifo_re);
endinterface

// File: rtl/fifo_uart_tx_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
// Latency: tick is a combinational decode of the count register.
// Backpressure: none; clear restarts the period from zero.
module fifo_uart_tx_baud_counter
   import fifo_uart_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);
   localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt;

   assign tick = (cnt == TERM);

   // Free-running count, reloaded at each bit boundary or when the FSM changes state
   always_ff @(posedge clk) begin
      if (rst || clear || tick) cnt <= '0;
      else                      cnt <= cnt + 1'b1;
   end
endmodule

// File: rtl/fifo_uart_tx.sv
// Drains bytes from a synchronous FIFO and serialises each as a start/data/stop UART frame.
// Latency: frame starts 2 cycles after fifo_empty falls in IDLE; frame lasts (1+WIDTH+STOP_BITS)*CLKS_PER_BIT cycles.
// Backpressure: fifo_empty is only looked at in IDLE, so bytes written mid-frame wait for the next frame.
module fifo_uart_tx
   import fifo_uart_tx_pkg::*;
#(
   parameter int WIDTH        = DATA_W,
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   fifo_uart_tx_if.slave        fif,
   output logic                 tx,
   output logic                 busy,
   output logic                 tx_done
);
   // bit_idx counts data bits in DATA and stop bits in STOP
   localparam int            BW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [BW-1:0] LAST_BIT  = BW'(WIDTH - 1);
   localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

   logic [2:0]       state, state_nxt;
   logic [WIDTH-1:0] shift, shift_nxt;
   logic [BW-1:0]    bit_idx, bit_idx_nxt;
   logic             tick;
   logic             baud_clear;
   logic             tx_nxt;

   // A read is only ever requested from IDLE, and never against an empty FIFO
   assign fif.fifo_re = (state == ST_IDLE) && !fif.fifo_empty;
   assign busy        = (state != ST_IDLE);
   assign tx_done     = (state == ST_STOP) && tick && (bit_idx == LAST_STOP);
   assign baud_clear  = (state_nxt != state);

   fifo_uart_tx_baud_counter #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .clk   (clk),
      .rst   (rst),
      .clear (baud_clear),
      .tick  (tick)
   );

   // Next-state, shift-register and bit-index decode
   always_comb begin
      state_nxt   = state;
      shift_nxt   = shift;
      bit_idx_nxt = bit_idx;
      case (state)
         ST_IDLE: begin
            if (!fif.fifo_empty) state_nxt = ST_LOAD;
         end
         ST_LOAD: begin
            // FIFO output register holds the byte requested in IDLE
            shift_nxt = fif.fifo_dout;
            state_nxt = ST_START;
         end
         ST_START: begin
            if (tick) begin
               state_nxt   = ST_DATA;
               bit_idx_nxt = '0;
            end
         end
         ST_DATA: begin
            if (tick) begin
               if (bit_idx == LAST_BIT) begin
                  state_nxt   = ST_STOP;
                  bit_idx_nxt = '0;
               end else begin
                  shift_nxt   = shift >> 1;
                  bit_idx_nxt = bit_idx + 1'b1;
               end
            end
         end
         ST_STOP: begin
            if (tick) begin
               if (bit_idx == LAST_STOP) begin
                  state_nxt   = ST_IDLE;
                  bit_idx_nxt = '0;
               end else begin
                  bit_idx_nxt = bit_idx + 1'b1;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Line level for the state being entered, so tx lines up with state after the register
   always_comb begin
      case (state_nxt)
         ST_START: tx_nxt = 1'b0;
         ST_DATA:  tx_nxt = shift_nxt[0];
         default:  tx_nxt = 1'b1;
      endcase
   end

   // State registers; reset drops any in-flight byte and returns the line to idle
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         shift   <= '0;
         bit_idx <= '0;
         tx      <= 1'b1;
      end else begin
         state   <= state_nxt;
         shift   <= shift_nxt;
         bit_idx <= bit_idx_nxt;
         tx      <= tx_nxt;
      end
   end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Testbench for fifo_uart_tx: FIFO models feed two instances (1 and 2 stop bits),
// per-cycle logs of the outputs are checked against a UART receiver model.
// Stimulus is applied 2 time units after posedge, outputs sampled on negedge.
module tb_fifo_uart_tx;
   localparam int CPB = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fifo_uart_tx_if #(.WIDTH(8)) if0 ();
   fifo_uart_tx_if #(.WIDTH(8)) if1 ();
   logic tx0, busy0, done0, tx1, busy1, done1;

   fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut0 (
      .clk(clk), .rst(rst), .fif(if0), .tx(tx0), .busy(busy0), .tx_done(done0));
   fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut1 (
      .clk(clk), .rst(rst), .fif(if1), .tx(tx1), .busy(busy1), .tx_done(done1));

   int checks = 0;
   int errors = 0;
   int uf_cnt = 0;

   logic [7:0] q0[$];
   logic [7:0] q1[$];
   logic       re0_s, re1_s;

   logic txl0[$], bl0[$], dl0[$], rl0[$];
   logic txl1[$], dl1[$];

   logic [7:0] rx_b[$];
   int         rx_s[$];
   int         rx_bad;

   // FIFO model 0: write lands next cycle, read data registered one cycle after fifo_re
   initial begin
      if0.fifo_empty = 1'b1;
      if0.fifo_dout  = '0;
      forever begin
         @(posedge clk); #1;
         if (re0_s && q0.size() > 0) if0.fifo_dout = q0.pop_front();
         if0.fifo_empty = (q0.size() == 0);
      end
   end

   // FIFO model 1
   initial begin
      if1.fifo_empty = 1'b1;
      if1.fifo_dout  = '0;
      forever begin
         @(posedge clk); #1;
         if (re1_s && q1.size() > 0) if1.fifo_dout = q1.pop_front();
         if1.fifo_empty = (q1.size() == 0);
      end
   end

   // Monitor: sample outputs mid-cycle into logs
   initial begin
      re0_s = 1'b0;
      re1_s = 1'b0;
      forever begin
         @(negedge clk);
         re0_s = if0.fifo_re;
         re1_s = if1.fifo_re;
         if (if0.fifo_re && q0.size() == 0) uf_cnt++;
         if (if1.fifo_re && q1.size() == 0) uf_cnt++;
         txl0.push_back(tx0); bl0.push_back(busy0); dl0.push_back(done0); rl0.push_back(if0.fifo_re);
         txl1.push_back(tx1); dl1.push_back(done1);
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic clear_logs();
      txl0.delete(); bl0.delete(); dl0.delete(); rl0.delete();
      txl1.delete(); dl1.delete();
   endtask

   function automatic logic at(input logic lg[$], input int i);
      if (i < 0 || i >= lg.size()) return 1'bx;
      return lg[i];
   endfunction

   function automatic int count_ones(input logic lg[$]);
      int n = 0;
      foreach (lg[i]) if (lg[i] === 1'b1) n++;
      return n;
   endfunction

   function automatic int nth_one(input logic lg[$], input int n);
      int seen = 0;
      foreach (lg[i]) if (lg[i] === 1'b1) begin
         if (seen == n) return i;
         seen++;
      end
      return -1;
   endfunction

   function automatic int first_zero(input logic lg[$]);
      foreach (lg[i]) if (lg[i] === 1'b0) return i;
      return -1;
   endfunction

   // Ideal line level at offset t into a 1-stop/2-stop frame carrying byte b
   function automatic logic exp_tx(input logic [7:0] b, input int t);
      int k;
      k = t / CPB;
      if (k == 0) return 1'b0;
      if (k <= 8) return b[k-1];
      return 1'b1;
   endfunction

   // UART receiver model: every bit must be held steady for CPB samples
   task automatic decode(input logic lg[$], input int stop);
      int         i, flen;
      logic [7:0] b;
      logic       v, ok;
      rx_b.delete(); rx_s.delete(); rx_bad = 0;
      flen = (1 + 8 + stop) * CPB;
      i = 0;
      while (i < lg.size()) begin
         if (lg[i] === 1'b0) begin
            if (i + flen > lg.size()) begin rx_bad++; break; end
            ok = 1'b1; b = '0;
            for (int k = 0; k < 9 + stop; k++) begin
               v = lg[i + k*CPB];
               for (int c = 1; c < CPB; c++) if (lg[i + k*CPB + c] !== v) ok = 1'b0;
               if (k == 0) begin
                  if (v !== 1'b0) ok = 1'b0;
               end else if (k <= 8) b[k-1] = v;
               else if (v !== 1'b1) ok = 1'b0;
            end
            if (!ok) rx_bad++;
            rx_b.push_back(b);
            rx_s.push_back(i);
            i += flen;
         end else i++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      clear_logs();
      @(negedge clk);
      checks++; if (tx0 !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", tx0); end
      checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy0); end
      checks++; if (if0.fifo_re !== 1'b0) begin errors++; $display("FAIL reset_re got %b want 0", if0.fifo_re); end
      checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done0); end
      step(50);
      checks++; if (count_ones(txl0) != txl0.size() || txl0.size() < 50)
         begin errors++; $display("FAIL reset_idle_tx high %0d of %0d", count_ones(txl0), txl0.size()); end
      checks++; if (count_ones(bl0) + count_ones(dl0) + count_ones(rl0) != 0)
         begin errors++; $display("FAIL reset_idle_flags got %0d asserted want 0", count_ones(bl0) + count_ones(dl0) + count_ones(rl0)); end
   endtask

   task automatic test_single();
      int s, mism;
      clear_logs();
      q0.push_back(8'hA5);
      step(60);
      s = first_zero(txl0);
      checks++; if (count_ones(rl0) != 1) begin errors++; $display("FAIL single_re_count got %0d want 1", count_ones(rl0)); end
      checks++; if (s < 2) begin errors++; $display("FAIL single_start got %0d want >=2", s); return; end
      mism = 0;
      for (int t = 0; t < 40; t++) if (at(txl0, s + t) !== exp_tx(8'hA5, t)) mism++;
      if (at(txl0, s + 40) !== 1'b1) mism++;
      checks++; if (mism != 0) begin errors++; $display("FAIL single_frame got %0d bad cycles want 0", mism); end
      checks++; if (nth_one(rl0, 0) != s - 2) begin errors++; $display("FAIL single_re_pos got %0d want %0d", nth_one(rl0, 0), s - 2); end
      checks++; if (count_ones(dl0) != 1 || nth_one(dl0, 0) != s + 39)
         begin errors++; $display("FAIL single_done got %0d pulses at %0d want 1 at %0d", count_ones(dl0), nth_one(dl0, 0), s + 39); end
      checks++; if (at(bl0, s + 39) !== 1'b1 || at(bl0, s + 40) !== 1'b0 || at(bl0, s - 1) !== 1'b1)
         begin errors++; $display("FAIL single_busy got %b%b%b want 110", at(bl0, s - 1), at(bl0, s + 39), at(bl0, s + 40)); end
   endtask

   task automatic test_drain();
      int bad_b, bad_g, bad_d;
      clear_logs();
      uf_cnt = 0;
      for (int i = 0; i < 16; i++) q0.push_back(8'(i));
      step(16 * 42 + 20);
      decode(txl0, 1);
      checks++; if (rx_b.size() != 16) begin errors++; $display("FAIL drain_frames got %0d want 16", rx_b.size()); end
      bad_b = 0; bad_g = 0; bad_d = 0;
      foreach (rx_b[k]) begin
         if (rx_b[k] !== 8'(k)) bad_b++;
         if (k > 0 && rx_s[k] - (rx_s[k-1] + 40) != 2) bad_g++;
         if (at(dl0, rx_s[k] + 39) !== 1'b1) bad_d++;
      end
      checks++; if (bad_b != 0 || rx_bad != 0) begin errors++; $display("FAIL drain_bytes got %0d wrong %0d malformed want 0", bad_b, rx_bad); end
      checks++; if (bad_g != 0) begin errors++; $display("FAIL drain_gap got %0d wrong gaps want 0", bad_g); end
      checks++; if (bad_d != 0 || count_ones(dl0) != 16) begin errors++; $display("FAIL drain_done got %0d pulses %0d misplaced want 16 0", count_ones(dl0), bad_d); end
      checks++; if (count_ones(rl0) != 16) begin errors++; $display("FAIL drain_re got %0d want 16", count_ones(rl0)); end
      checks++; if (uf_cnt != 0) begin errors++; $display("FAIL drain_underflow got %0d want 0", uf_cnt); end
   endtask

   task automatic test_write_during_tx();
      int d;
      clear_logs();
      q0.push_back(8'h81);
      step(20);
      q0.push_back(8'h3C);
      step(110);
      decode(txl0, 1);
      checks++; if (rx_b.size() != 2 || rx_bad != 0) begin errors++; $display("FAIL wdt_frames got %0d (%0d malformed) want 2", rx_b.size(), rx_bad); end
      else begin
         checks++; if (rx_b[0] !== 8'h81 || rx_b[1] !== 8'h3C) begin errors++; $display("FAIL wdt_bytes got %h %h want 81 3c", rx_b[0], rx_b[1]); end
         checks++; if (rx_s[1] - (rx_s[0] + 40) != 2) begin errors++; $display("FAIL wdt_gap got %0d want 2", rx_s[1] - (rx_s[0] + 40)); end
      end
      d = nth_one(dl0, 0);
      checks++; if (count_ones(rl0) != 2 || nth_one(rl0, 1) != d + 1)
         begin errors++; $display("FAIL wdt_fetch got %0d reads second at %0d want 2 at %0d", count_ones(rl0), nth_one(rl0, 1), d + 1); end
   endtask

   task automatic test_reset_mid();
      clear_logs();
      q0.push_back(8'hFF);
      q0.push_back(8'h55);
      step(20);
      checks++; if (at(bl0, 19) !== 1'b1 || at(txl0, 3) !== 1'b0)
         begin errors++; $display("FAIL rmid_inflight got busy %b start %b want 1 0", at(bl0, 19), at(txl0, 3)); end
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      clear_logs();
      @(negedge clk);
      checks++; if (tx0 !== 1'b1 || busy0 !== 1'b0) begin errors++; $display("FAIL rmid_after got tx %b busy %b want 1 0", tx0, busy0); end
      step(70);
      decode(txl0, 1);
      checks++; if (rx_b.size() != 1 || rx_bad != 0 || (rx_b.size() == 1 && rx_b[0] !== 8'h55))
         begin errors++; $display("FAIL rmid_resume got %0d frames (%0d malformed) want one 55", rx_b.size(), rx_bad); end
      checks++; if (count_ones(rl0) != 1 || q0.size() != 0)
         begin errors++; $display("FAIL rmid_reads got %0d left %0d want 1 0", count_ones(rl0), q0.size()); end
   endtask

   task automatic test_stop2();
      int s, lo, hi;
      clear_logs();
      q1.push_back(8'h00);
      step(60);
      s = first_zero(txl1);
      lo = 0; hi = 0;
      for (int t = 0; t < 36; t++) if (at(txl1, s + t) === 1'b0) lo++;
      for (int t = 36; t < 44; t++) if (at(txl1, s + t) === 1'b1) hi++;
      checks++; if (s < 2 || lo != 36 || hi != 8) begin errors++; $display("FAIL stop2_shape got start %0d low %0d high %0d want low 36 high 8", s, lo, hi); end
      checks++; if (count_ones(dl1) != 1 || nth_one(dl1, 0) != s + 43)
         begin errors++; $display("FAIL stop2_done got %0d at %0d want 1 at %0d", count_ones(dl1), nth_one(dl1, 0), s + 43); end
      decode(txl1, 2);
      checks++; if (rx_b.size() != 1 || rx_bad != 0) begin errors++; $display("FAIL stop2_decode got %0d frames %0d malformed want 1 0", rx_b.size(), rx_bad); end
   endtask

   task automatic test_random();
      logic [7:0] expq[$];
      logic [7:0] b;
      int         bad_b, bad_g;
      clear_logs();
      uf_cnt = 0;
      for (int i = 0; i < 24; i++) begin
         step($urandom_range(1, 50));
         b = 8'($urandom);
         q0.push_back(b);
         expq.push_back(b);
      end
      step(24 * 42 + 20);
      decode(txl0, 1);
      checks++; if (rx_b.size() != expq.size()) begin errors++; $display("FAIL rand_frames got %0d want %0d", rx_b.size(), expq.size()); end
      bad_b = 0; bad_g = 0;
      foreach (rx_b[k]) begin
         if (k >= expq.size() || rx_b[k] !== expq[k]) bad_b++;
         if (k > 0 && rx_s[k] - (rx_s[k-1] + 40) < 2) bad_g++;
      end
      checks++; if (bad_b != 0 || rx_bad != 0) begin errors++; $display("FAIL rand_bytes got %0d wrong %0d malformed want 0", bad_b, rx_bad); end
      checks++; if (bad_g != 0) begin errors++; $display("FAIL rand_gap got %0d short gaps want 0", bad_g); end
      checks++; if (count_ones(rl0) != 24 || count_ones(dl0) != 24 || uf_cnt != 0)
         begin errors++; $display("FAIL rand_counts got re %0d done %0d uf %0d want 24 24 0", count_ones(rl0), count_ones(dl0), uf_cnt); end
   endtask

   initial begin
      rst = 1'b1;
      test_reset();
      test_single();
      test_drain();
      test_write_during_tx();
      test_reset_mid();
      test_stop2();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
